// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder/subtractor: one 4-bit ripple adder reused over WIDTH/4 cycles,
// with a registered inter-nibble carry and valid/ready handshakes on both sides.

module ripple_carry_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] out,
    output logic       carry_out
);
    logic [4:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign out[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry_out = c[4];
endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [3:0]       nib_a, nib_b, nib_sum;
    logic             nib_co;

    ripple_carry_adder_4_bit u_rca (
        .a         (nib_a),
        .b         (nib_b),
        .carry_in  (c_q),
        .out       (nib_sum),
        .carry_out (nib_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)       state_d = S_RUN;
            S_RUN:   if (idx_q == LAST)  state_d = S_DONE;
            S_DONE:  if (out_ready)      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Handshake flags decode from state only, never from the partner's valid/ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Nibble mux feeding the shared adder.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx_q == IW'(k)) begin
                nib_a = a_q[4*k +: 4];
                nib_b = b_q[4*k +: 4];
            end
        end
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        c_d   = c_q;
        ovf_d = ovf_q;
        idx_d = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = sub ? ~b : b;
                    c_d   = sub;
                    idx_d = '0;
                end
            end
            S_RUN: begin
                for (int k = 0; k < int'(N); k++) begin
                    if (idx_q == IW'(k)) sum_d[4*k +: 4] = nib_sum;
                end
                c_d   = nib_co;
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
            idx_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            idx_q <= idx_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = c_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): directed operations push expected
// results; a negedge monitor pops and compares on every output handshake.

module tb_nibble_serial_adder;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on every completed output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("carry_out", 32'(carry_out), 32'(e.co));
                check("overflow", 32'(overflow), 32'(e.ov));
            end
        end
    end

    // Drive one operand set; returns after the accepting edge (+1).
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(0), 32'(1));
        a = av; b = bv; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(0), 32'(1));
    endtask

    task automatic push(input logic [W-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.sum = s; e.co = co; e.ov = ov;
        sb_q.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                          input logic [W-1:0] es, input logic eco, input logic eov);
        push(es, eco, eov);
        issue(av, bv, s);
        wait_valid();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_carry", 32'(carry_out), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));

        // 0x1234 + 0x4321: observe nibbles landing in order, valid after 4 cycles.
        push(16'h5555, 1'b0, 1'b0);
        issue(16'h1234, 16'h4321, 1'b0);
        check("busy_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        check("nib1_sum", 32'(sum), 32'h0005);
        check("nib1_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        check("nib2_sum", 32'(sum), 32'h0055);
        @(posedge clk); #1;
        check("nib3_sum", 32'(sum), 32'h0555);
        check("nib3_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        check("lat4_valid", 32'(out_valid), 32'(1));
        @(posedge clk); #1;
        check("after_done_idle", 32'(in_ready), 32'(1));

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: 0x0005 - 0x0007 held in DONE while new operands wait.
        out_ready = 1'b0;
        push(16'hFFFE, 1'b0, 1'b0);
        issue(16'h0005, 16'h0007, 1'b1);
        wait_valid();
        a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_sum", 32'(sum), 32'hFFFE);
        end
        out_ready = 1'b1;
        push(16'h3333, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("bp_idle_in_ready", 32'(in_ready), 32'(1));
        check("bp_idle_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        check("bp_accepted", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        wait_valid();
        @(posedge clk); #1;

        // Reset during RUN cycle 2 of 0x1234 + 0x4321; nothing expected from it.
        issue(16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_sum", 32'(sum), 32'(0));
        check("mid_rst_carry", 32'(carry_out), 32'(0));
        check("mid_rst_ovf", 32'(overflow), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Nibble-serial WIDTH-bit adder/subtractor that time-multiplexes a single `ripple_carry_adder_4_bit` instance over WIDTH/4 cycles, carrying between nibbles through a registered carry. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area: one 4-bit adder serves any operand width.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and ≥ 8. N = WIDTH/4 nibbles.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand transfer request.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `sub` input 1: 0 = A+B, 1 = A−B.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: result, registered.
- `carry_out` output 1: final carry. For subtract, 1 = no borrow.
- `overflow` output 1: two's-complement signed overflow.

## Operation
- Exactly one `ripple_carry_adder_4_bit` instance, used unmodified. No other adder logic in the datapath.
- FSM states and transitions:
  - IDLE: `in_ready`=1. If `in_valid`=1 at an edge, the operation is accepted:
    - `a_reg` ← a.
    - `b_reg` ← sub ? ~b : b.
    - `c_reg` ← sub.
    - `sub_reg` ← sub.
    - `idx` ← 0.
    - Go to RUN.
  - RUN: adder inputs are `a_reg[4*idx+3:4*idx]`, `b_reg[4*idx+3:4*idx]` and `carry_in` = `c_reg`. Each edge:
    - Adder `out` is written into result nibble `idx`.
    - `c_reg` ← adder `carry_out`.
    - `idx` increments.
    - On the edge with `idx` = N−1, go to DONE.
  - DONE: `out_valid`=1. `sum`, `carry_out` and `overflow` are stable. When `out_ready`=1 at an edge, go to IDLE.
- Flag rules:
  - `carry_out` is the `c_reg` value after the last nibble.
  - `overflow` = (`a_reg[W−1]` == `b_reg[W−1]`) && (`sum[W−1]` != `a_reg[W−1]`), where `b_reg` is the inverted operand when subtracting.
- Flow control:
  - `in_ready`=0 in RUN and DONE. `in_valid` is ignored there, and operands are not sampled.
  - `a`, `b` and `sub` are sampled only on the accepting edge. Later changes have no effect.
  - A new operation can start in the cycle after a DONE→IDLE transition. There is no IDLE-bypass.
- Result registers hold their last value in IDLE until the next operation overwrites them nibble by nibble. Consumers must use `sum` only while `out_valid`=1.
- Reset, asynchronous and taking effect at any time including mid-RUN or DONE:
  - State → IDLE; any in-flight operation is discarded with no output.
  - All registers → 0.
  - `in_ready`=1 while reset is deasserted in IDLE.
  - `out_valid`=0, `sum`=0, `carry_out`=0, `overflow`=0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `carry_out`=0, `overflow`=0.
- Latency: operands accepted at edge E0. Nibble k is computed in the cycle after edge E(k) and registered at E(k+1). `out_valid` rises after edge E(N), i.e. N cycles after acceptance (4 cycles at WIDTH=16).
- Throughput: with `out_ready` held at 1, one operation per N+2 cycles (N in RUN, 1 in DONE, 1 in IDLE).
- `out_valid` and the result fields stay constant for as long as `out_ready`=0. There is no timeout.
- Handshakes complete only on an edge where valid and ready are both 1. `in_ready` and `out_valid` depend on state only, never combinationally on `in_valid` or `out_ready`.
- Critical path: one 4-bit ripple plus the nibble mux. It does not scale with WIDTH.

## Test plan
All scenarios use WIDTH=16.
- Add 0x1234 + 0x4321, sub=0 → after 4 cycles `out_valid`=1, `sum`=0x5555, `carry_out`=0, `overflow`=0. Intermediate nibbles update in order 5, 55, 555.
- Add 0xFFFF + 0x0001 → `sum`=0x0000, `carry_out`=1, `overflow`=0. Carry ripples across all 4 cycles.
- Add 0x7FFF + 0x0001 → `sum`=0x8000, `carry_out`=0, `overflow`=1.
- Subtract:
  - 0x0005 − 0x0007 → `sum`=0xFFFE, `carry_out`=0, `overflow`=0.
  - 0x8000 − 0x0001 → `sum`=0x7FFF, `carry_out`=1, `overflow`=1.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles in DONE while driving `in_valid`=1 with new operands → result held, `in_ready`=0, new operands not taken.
  - Then `out_ready`=1 → IDLE next cycle, and the new operands are accepted on the following edge.
- Reset mid-operation:
  - Assert `reset` during RUN cycle 2 of 0x1234+0x4321 → all outputs 0 immediately, `in_ready`=1 after release.
  - A following 0x0001+0x0001 → `sum`=0x0002 with no residue from the aborted operation.
